// File: rtl/player_datapath.sv
// Player sprite datapath: 8x8 sprite pixel scanner plus vertical jump/gravity
// motion state machine. Produces one sprite pixel (x, y, colour) per cycle.
module player_datapath #(
  parameter logic [7:0] PLAYER_X      = 8'd20,
  parameter logic [6:0] GROUND_Y      = 7'd100,
  parameter logic [6:0] JUMP_STEP     = 7'd4,
  parameter logic [6:0] FALL_STEP     = 7'd2,
  parameter logic [6:0] JUMP_MAX      = 7'd32,
  parameter logic [2:0] PLAYER_COLOUR = 3'b110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       drawC,
  input  logic       enableCountXC,
  input  logic       countUp,
  input  logic       countDown,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       doneC,
  output logic       ground
);

  localparam logic [1:0] GROUNDED = 2'd0;
  localparam logic [1:0] RISING   = 2'd1;
  localparam logic [1:0] FALLING  = 2'd2;

  logic [5:0] r_offset;
  logic [6:0] r_y_pos;
  logic [6:0] r_rise;
  logic [1:0] r_state;
  logic [1:0] w_next_state;

  logic [2:0] w_col;
  logic [2:0] w_row;
  logic [7:0] w_rise_sum;
  logic       w_can_rise;
  logic [6:0] w_y_up;
  logic [6:0] w_y_down;
  logic       w_landing;
  logic       w_rst;

  // Moving up the screen decreases y; never wrap below row 0.
  function automatic logic [6:0] sat_sub(input logic [6:0] a, input logic [6:0] b);
    return (a < b) ? 7'd0 : (a - b);
  endfunction

  // Moving down the screen increases y; stop exactly at the ground row.
  function automatic logic [6:0] clamp_add(input logic [6:0] a, input logic [6:0] b,
                                           input logic [6:0] lim);
    logic [7:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, lim}) ? lim : s[6:0];
  endfunction

  assign w_rst      = reset | clear;
  assign w_col      = r_offset[2:0];
  assign w_row      = r_offset[5:3];
  assign w_rise_sum = {1'b0, r_rise} + {1'b0, JUMP_STEP};
  assign w_can_rise = (w_rise_sum <= {1'b0, JUMP_MAX});
  assign w_y_up     = sat_sub(r_y_pos, JUMP_STEP);
  assign w_y_down   = clamp_add(r_y_pos, FALL_STEP, GROUND_Y);
  assign w_landing  = (w_y_down == GROUND_Y);

  // Sprite pixel offset: scans the 8x8 sprite, wrapping 63 -> 0.
  always_ff @(posedge clk) begin
    if (w_rst)
      r_offset <= 6'd0;
    else if (enableCountXC)
      r_offset <= r_offset + 6'd1;
  end

  // Pixel address/colour; eyes at row 1, cols 2 and 5 stay black.
  always_comb begin
    x_out      = PLAYER_X + {5'b0, w_col};
    y_out      = r_y_pos + {4'b0, w_row};
    doneC      = (r_offset == 6'd63);
    colour_out = 3'b000;
    if (drawC && !((w_row == 3'd1) && ((w_col == 3'd2) || (w_col == 3'd5))))
      colour_out = PLAYER_COLOUR;
  end

  // Motion state register.
  always_ff @(posedge clk) begin
    if (w_rst)
      r_state <= GROUNDED;
    else
      r_state <= w_next_state;
  end

  // Motion next state; countUp wins over countDown when both are high.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      GROUNDED: if (countUp) w_next_state = RISING;
      RISING: begin
        if (countUp)
          w_next_state = w_can_rise ? RISING : FALLING;
        else if (countDown)
          w_next_state = w_landing ? GROUNDED : FALLING;
      end
      FALLING: begin
        if (!countUp && countDown)
          w_next_state = w_landing ? GROUNDED : FALLING;
      end
      default: w_next_state = GROUNDED;
    endcase
  end

  // Motion outputs: ground flag decoded from the registered state.
  always_comb begin
    ground = (r_state == GROUNDED);
  end

  // Vertical position and accumulated rise for the current jump.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_y_pos <= GROUND_Y;
      r_rise  <= 7'd0;
    end else if (countUp) begin
      if ((r_state == GROUNDED) || ((r_state == RISING) && w_can_rise)) begin
        r_y_pos <= w_y_up;
        r_rise  <= w_rise_sum[6:0];
      end
    end else if (countDown && (r_state != GROUNDED)) begin
      r_y_pos <= w_y_down;
      if (w_landing)
        r_rise <= 7'd0;
    end
  end

endmodule
